axil_slave: RTL and testbench

AXI4-Lite responder that terminates the write-address/write-data and read-address/read-data channels driven by the design's AXI-Lite master FSMs. It converts each accepted transaction into a single-beat request on a shared backend register port with an ack handshake. One write FSM, one read FSM and a fixed-priority backend arbiter; one transaction in flight per direction. No B channel; writes are acknowledged only through AW/W acceptance.

---
 rtl/axil_slave.sv | 150 +++++++++++++++
 tb/tb_axil_slave.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave.sv
// AXI4-Lite responder: terminates AW/W and AR/R, turns each accepted
// transaction into a single-beat request on a shared backend register port.
// One write FSM, one read FSM, fixed-priority (write first) backend arbiter.
module axil_slave #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awready,
  input  logic                    axi_wvalid,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wready,
  input  logic                    axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_arready,
  output logic                    axi_rvalid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rready,
  output logic                    bk_wr,
  output logic                    bk_rd,
  output logic [ADDR_WIDTH-1:0]   bk_addr,
  output logic [DATA_WIDTH-1:0]   bk_wdata,
  output logic [DATA_WIDTH/8-1:0] bk_wstrb,
  input  logic                    bk_ack,
  input  logic [DATA_WIDTH-1:0]   bk_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_BACKEND} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_BACKEND, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_WR = 2'd1, GNT_RD = 2'd2} grant_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  grant_t    grant, grant_next;

  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q, rd_data_q;
  logic [STRB_WIDTH-1:0] wr_strb_q;

  logic aw_fire, w_fire, ar_fire, r_fire, wr_done, rd_done;

  assign aw_fire = axi_awvalid & axi_awready;
  assign w_fire  = axi_wvalid & axi_wready;
  assign ar_fire = axi_arvalid & axi_arready;
  assign r_fire  = axi_rvalid & axi_rready;
  // An ack only completes the request that currently owns the backend.
  assign wr_done = bk_ack & (grant == GNT_WR);
  assign rd_done = bk_ack & (grant == GNT_RD);

  // Write FSM next state: address first, then data, then backend access.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:    if (aw_fire) wr_next = WR_DATA;
      WR_DATA:    if (w_fire)  wr_next = WR_BACKEND;
      WR_BACKEND: if (wr_done) wr_next = WR_IDLE;
      default:    wr_next = WR_IDLE;
    endcase
  end

  // Read FSM next state: address, backend access, then hold response until taken.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:    if (ar_fire) rd_next = RD_BACKEND;
      RD_BACKEND: if (rd_done) rd_next = RD_RESP;
      RD_RESP:    if (r_fire)  rd_next = RD_IDLE;
      default:    rd_next = RD_IDLE;
    endcase
  end

  // Arbiter: grant on the cycle a BACKEND state is entered, write wins ties,
  // and the grant always passes through NONE after an ack.
  always_comb begin
    grant_next = grant;
    case (grant)
      GNT_NONE: begin
        if (wr_next == WR_BACKEND)      grant_next = GNT_WR;
        else if (rd_next == RD_BACKEND) grant_next = GNT_RD;
      end
      GNT_WR, GNT_RD: if (bk_ack) grant_next = GNT_NONE;
      default: grant_next = GNT_NONE;
    endcase
  end

  // State, grant and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= WR_IDLE;
      rd_state    <= RD_IDLE;
      grant       <= GNT_NONE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
    end else begin
      wr_state    <= wr_next;
      rd_state    <= rd_next;
      grant       <= grant_next;
      axi_awready <= (wr_next == WR_IDLE);
      axi_wready  <= (wr_next == WR_DATA);
      axi_arready <= (rd_next == RD_IDLE);
      axi_rvalid  <= (rd_next == RD_RESP);
    end
  end

  // Transaction fields captured at their handshakes, held for the backend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (aw_fire) wr_addr_q <= axi_awaddr;
      if (w_fire) begin
        wr_data_q <= axi_wdata;
        wr_strb_q <= axi_wstrb;
      end
      if (ar_fire) rd_addr_q <= axi_araddr;
      if (rd_done) rd_data_q <= bk_rdata;
    end
  end

  // Backend request fields come from the granted side, zero when idle.
  always_comb begin
    bk_addr  = '0;
    bk_wdata = '0;
    bk_wstrb = '0;
    if (grant == GNT_WR) begin
      bk_addr  = wr_addr_q;
      bk_wdata = wr_data_q;
      bk_wstrb = wr_strb_q;
    end else if (grant == GNT_RD) begin
      bk_addr  = rd_addr_q;
    end
  end

  assign bk_wr     = (grant == GNT_WR);
  assign bk_rd     = (grant == GNT_RD);
  assign axi_rdata = (rd_state == RD_RESP) ? rd_data_q : '0;

endmodule

// File: tb/tb_axil_slave.sv
// Self-checking bench for axil_slave: a table of directed transactions plus
// hand-written sequences for contention, early W, spurious ack and mid-flight reset.
module tb_axil_slave;

  localparam int TIMEOUT = 60;

  logic        clk, rst_n;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [14:0] axi_awaddr, axi_araddr;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        bk_wr, bk_rd, bk_ack;
  logic [14:0] bk_addr;
  logic [31:0] bk_wdata, bk_rdata;
  logic [3:0]  bk_wstrb;

  axil_slave dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready),
    .bk_wr(bk_wr), .bk_rd(bk_rd), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
    .bk_wstrb(bk_wstrb), .bk_ack(bk_ack), .bk_rdata(bk_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Backend model controls and observations.
  logic [31:0] mem [256];
  int   stall_cycles = 0;
  int   stall_cnt    = 0;
  bit   ack_enable   = 1;
  bit   spurious     = 0;
  bit   mon_en       = 0;
  int   wr_acks = 0, rd_acks = 0, wr_req_cycles = 0;
  int   wr_start = -1, rd_start = -1;
  bit   prev_wr = 0, prev_rd = 0, prev_active = 0;
  logic [50:0] prev_fields;
  logic [14:0] last_wr_addr, last_rd_addr;
  logic [31:0] last_wr_data;
  logic [3:0]  last_wr_strb;
  int   ack_log[$];

  typedef struct {
    bit          is_wr;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          stall;
    int          rdelay;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Backend responder: answers after stall_cycles wait cycles, applies strobes to the model memory.
  always @(posedge clk) begin
    #1;
    bk_ack   = 1'b0;
    bk_rdata = 32'h0;
    if (rst_n && ack_enable && (bk_wr || bk_rd)) begin
      if (stall_cnt < stall_cycles) stall_cnt++;
      else begin
        bk_ack    = 1'b1;
        stall_cnt = 0;
        if (bk_wr) begin
          for (int i = 0; i < 4; i++)
            if (bk_wstrb[i]) mem[bk_addr[9:2]][8*i +: 8] = bk_wdata[8*i +: 8];
        end else begin
          bk_rdata = mem[bk_addr[9:2]];
        end
      end
    end else begin
      stall_cnt = 0;
      if (spurious) bk_ack = 1'b1;
    end
  end

  // Bus monitor: records backend activity and checks per-cycle invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bk_wr) wr_req_cycles++;
      if (bk_wr && !prev_wr) wr_start = cycle;
      if (bk_rd && !prev_rd) rd_start = cycle;
      if (bk_wr && bk_ack) begin
        wr_acks++;
        last_wr_addr = bk_addr;
        last_wr_data = bk_wdata;
        last_wr_strb = bk_wstrb;
        ack_log.push_back(1);
      end
      if (bk_rd && bk_ack) begin
        rd_acks++;
        last_rd_addr = bk_addr;
        ack_log.push_back(2);
      end
      checkOutput("bk_one_hot", {63'h0, bk_wr & bk_rd}, 64'h0);
      if ((bk_wr || bk_rd) && prev_active)
        checkOutput("bk_fields_stable", {13'h0, bk_addr, bk_wdata, bk_wstrb}, {13'h0, prev_fields});
      if (!bk_wr && !bk_rd)
        checkOutput("bk_fields_idle_zero", {13'h0, bk_addr, bk_wdata, bk_wstrb}, 64'h0);
      if (!axi_rvalid)
        checkOutput("rdata_idle_zero", {32'h0, axi_rdata}, 64'h0);
      prev_active = (bk_wr || bk_rd) && !bk_ack;
      prev_fields = {bk_addr, bk_wdata, bk_wstrb};
      prev_wr     = bk_wr;
      prev_rd     = bk_rd;
    end
  end

  task automatic doWrite(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int hs_c, output int whs_c, output int back_c);
    bit aw_fire, w_fire;
    hs_c = -1; whs_c = -1; back_c = -1;
    @(negedge clk);
    axi_awvalid = 1; axi_awaddr = a;
    axi_wvalid  = 1; axi_wdata  = d; axi_wstrb = s;
    for (int n = 0; n < TIMEOUT; n++) begin
      aw_fire = axi_awvalid && axi_awready;
      w_fire  = axi_wvalid && axi_wready;
      if (aw_fire) hs_c = cycle;
      if (w_fire) whs_c = cycle;
      if (hs_c >= 0 && whs_c >= 0 && !axi_awvalid && !axi_wvalid && axi_awready) begin
        back_c = cycle;
        break;
      end
      @(negedge clk);
      if (aw_fire) axi_awvalid = 0;
      if (w_fire) axi_wvalid = 0;
    end
    axi_awvalid = 0;
    axi_wvalid  = 0;
  endtask

  task automatic doRead(input logic [14:0] a, input int rdelay, output logic [31:0] data,
                        output int hs_c, output int back_c, output int rv, output int bad);
    bit ar_fire, r_fire;
    hs_c = -1; back_c = -1; rv = 0; bad = 0; data = 32'h0;
    @(negedge clk);
    axi_arvalid = 1; axi_araddr = a; axi_rready = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      ar_fire = axi_arvalid && axi_arready;
      r_fire  = 0;
      if (ar_fire) hs_c = cycle;
      if (axi_rvalid) begin
        if (rv == 0) data = axi_rdata;
        else if (axi_rdata !== data) bad++;
        if (axi_arready) bad++;
        if (rv >= rdelay) begin
          axi_rready = 1;
          r_fire = 1;
        end else axi_rready = 0;
        rv++;
      end
      if (hs_c >= 0 && rv > 0 && !axi_rvalid && !axi_arvalid && axi_arready) begin
        back_c = cycle;
        break;
      end
      @(negedge clk);
      if (ar_fire) axi_arvalid = 0;
      if (r_fire) axi_rready = 0;
    end
    axi_arvalid = 0;
    axi_rready  = 0;
  endtask

  // Applies one table vector and checks handshake timing and backend fields.
  task automatic applyStimulus(input vec_t v, input int idx);
    int hs, whs, back, rv, bad, acks0, req0;
    logic [31:0] d;
    stall_cycles = v.stall;
    if (v.is_wr) begin
      acks0 = wr_acks; req0 = wr_req_cycles;
      doWrite(v.addr, v.data, v.strb, hs, whs, back);
      checkOutput($sformatf("v%0d_wready_offset", idx), whs - hs, 1);
      checkOutput($sformatf("v%0d_bkwr_offset", idx), wr_start - hs, 2);
      checkOutput($sformatf("v%0d_awready_back", idx), back - hs, 3 + v.stall);
      checkOutput($sformatf("v%0d_wr_acks", idx), wr_acks - acks0, 1);
      checkOutput($sformatf("v%0d_bkwr_cycles", idx), wr_req_cycles - req0, v.stall + 1);
      checkOutput($sformatf("v%0d_bk_addr", idx), last_wr_addr, v.addr);
      checkOutput($sformatf("v%0d_bk_wdata", idx), last_wr_data, v.data);
      checkOutput($sformatf("v%0d_bk_wstrb", idx), last_wr_strb, v.strb);
    end else begin
      acks0 = rd_acks;
      doRead(v.addr, v.rdelay, d, hs, back, rv, bad);
      checkOutput($sformatf("v%0d_rdata", idx), d, v.exp_rdata);
      checkOutput($sformatf("v%0d_rvalid_cycles", idx), rv, v.rdelay + 1);
      checkOutput($sformatf("v%0d_r_hold_bad", idx), bad, 0);
      checkOutput($sformatf("v%0d_bkrd_offset", idx), rd_start - hs, 1);
      checkOutput($sformatf("v%0d_arready_back", idx), back - hs, 3 + v.stall + v.rdelay);
      checkOutput($sformatf("v%0d_rd_acks", idx), rd_acks - acks0, 1);
      checkOutput($sformatf("v%0d_bk_raddr", idx), last_rd_addr, v.addr);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int hsw, whs, backw, hsr, backr, rv, bad, acks0, reqs0, racks0;
  logic [31:0] rd_val;

  initial begin
    rst_n = 0;
    axi_awvalid = 0; axi_awaddr = 0; axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0;
    axi_arvalid = 0; axi_araddr = 0; axi_rready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8]   = 32'h12345678;
    mem[12]  = 32'h11223344;
    mem[16]  = 32'h0BADF00D;
    mem[255] = 32'hCAFEF00D;

    vecs[0] = '{1, 15'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
    vecs[1] = '{0, 15'h0020, 32'h0, 4'h0, 0, 0, 32'h12345678};
    vecs[2] = '{0, 15'h0020, 32'h0, 4'h0, 0, 3, 32'h12345678};
    vecs[3] = '{1, 15'h0030, 32'hA5A5A5A5, 4'h3, 2, 0, 32'h0};
    vecs[4] = '{0, 15'h0030, 32'h0, 4'h0, 1, 0, 32'h1122A5A5};
    vecs[5] = '{1, 15'h0040, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h0};
    vecs[6] = '{0, 15'h0040, 32'h0, 4'h0, 0, 0, 32'h0BADF00D};
    vecs[7] = '{0, 15'h7FFC, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D};
    vecs[8] = '{0, 15'h0010, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {axi_awready, axi_wready, axi_arready, axi_rvalid, bk_wr, bk_rd}, 6'b0);
    checkOutput("reset_fields", {13'h0, bk_addr, bk_wdata, bk_wstrb}, 64'h0);
    checkOutput("reset_rdata", axi_rdata, 32'h0);
    rst_n = 1;
    @(negedge clk);
    checkOutput("post_reset_ready", {axi_awready, axi_wready, axi_arready, axi_rvalid}, 4'b1010);
    mon_en = 1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // bk_ack with nothing granted must be ignored
    acks0 = wr_acks; racks0 = rd_acks;
    spurious = 1;
    repeat (3) @(negedge clk);
    spurious = 0;
    checkOutput("spurious_ready", {axi_awready, axi_wready, axi_arready, axi_rvalid}, 4'b1010);
    checkOutput("spurious_acks", (wr_acks - acks0) + (rd_acks - racks0), 0);

    // Write and read entering BACKEND together: write first, read sees new data
    stall_cycles = 0;
    fork
      doWrite(15'h0004, 32'h600DCAFE, 4'hF, hsw, whs, backw);
      begin
        @(negedge clk);
        doRead(15'h0004, 0, rd_val, hsr, backr, rv, bad);
      end
    join
    checkOutput("contend_ar_offset", hsr - hsw, 1);
    checkOutput("contend_bkwr_offset", wr_start - hsw, 2);
    checkOutput("contend_order", ack_log[ack_log.size()-2] * 4 + ack_log[ack_log.size()-1], 6);
    checkOutput("contend_rd_after_wr", rd_start > wr_start, 1);
    checkOutput("contend_rdata", rd_val, 32'h600DCAFE);

    // W presented two cycles ahead of AW
    acks0 = wr_acks; reqs0 = wr_req_cycles;
    @(negedge clk);
    axi_wvalid = 1; axi_wdata = 32'h0F0F0F0F; axi_wstrb = 4'hF;
    checkOutput("wlead_wready_0", axi_wready, 0);
    @(negedge clk);
    checkOutput("wlead_wready_1", axi_wready, 0);
    @(negedge clk);
    axi_awvalid = 1; axi_awaddr = 15'h0050;
    checkOutput("wlead_aw_cycle", {axi_awready, axi_wready}, 2'b10);
    @(negedge clk);
    axi_awvalid = 0;
    checkOutput("wlead_wready_after_aw", axi_wready, 1);
    @(negedge clk);
    axi_wvalid = 0;
    checkOutput("wlead_bkwr", {bk_wr, bk_addr}, {1'b1, 15'h0050});
    repeat (4) @(negedge clk);
    checkOutput("wlead_one_write", wr_acks - acks0, 1);
    checkOutput("wlead_req_cycles", wr_req_cycles - reqs0, 1);
    checkOutput("wlead_mem", mem[20], 32'h0F0F0F0F);

    // Reset while WR_BACKEND waits for an ack that never comes
    ack_enable = 0;
    acks0 = wr_acks;
    @(negedge clk);
    axi_awvalid = 1; axi_awaddr = 15'h0100; axi_wvalid = 1; axi_wdata = 32'h55AA55AA; axi_wstrb = 4'hF;
    @(negedge clk);
    axi_awvalid = 0;
    @(negedge clk);
    axi_wvalid = 0;
    checkOutput("rst_pre_bkwr", bk_wr, 1);
    repeat (2) @(negedge clk);
    checkOutput("rst_pre_bkwr_held", bk_wr, 1);
    #2 rst_n = 0;
    #1;
    checkOutput("rst_mid_ctrl", {axi_awready, axi_wready, axi_arready, axi_rvalid, bk_wr, bk_rd}, 6'b0);
    checkOutput("rst_mid_fields", {13'h0, bk_addr, bk_wdata, bk_wstrb}, 64'h0);
    checkOutput("rst_mid_rdata", axi_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    ack_enable = 1;
    reqs0 = wr_req_cycles;
    repeat (5) @(negedge clk);
    checkOutput("rst_no_req_after", wr_req_cycles - reqs0, 0);
    checkOutput("rst_no_ack_after", wr_acks - acks0, 0);
    checkOutput("rst_awready_back", {axi_awready, axi_arready}, 2'b11);
    applyStimulus('{1, 15'h0060, 32'hC0FFEE11, 4'hF, 0, 0, 32'h0}, 100);
    applyStimulus('{0, 15'h0060, 32'h0, 4'h0, 0, 0, 32'hC0FFEE11}, 101);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
